// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - shared word, metadata and header-decode types for the chiplet link
package chiplet_types_pkg;

  typedef logic [31:0] word_t;

  localparam int PKT_LENGTH_WIDTH = 8;

  typedef struct packed {
    logic [4:0] id;
    logic [1:0] req;
  } flit_meta_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_CRC_WAIT,
    ST_SEND_CRC
  } tx_state_t;

  // Header low byte carries the total non-CRC flit count, header included.
  function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(input word_t header);
    return header[PKT_LENGTH_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/socetlib_crc.sv
// rtl/socetlib_crc.sv - CRC-32 (poly 04C11DB7, init all-ones, MSB first), one byte per cycle
module socetlib_crc
  import chiplet_types_pkg::*;
(
  input  logic  clk,
  input  logic  n_rst,
  input  logic  clear,
  input  logic  update,
  input  word_t in,
  output word_t crc_out,
  output logic  done
);

  localparam word_t POLY = 32'h04C11DB7;

  word_t      crc_q, crc_d;
  word_t      data_q, data_d;
  logic [2:0] left_q, left_d;

  function automatic word_t crc_byte(input word_t c, input logic [7:0] b);
    word_t r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d  = crc_q;
    data_d = data_q;
    left_d = left_q;
    if (clear) begin
      crc_d  = '1;
      left_d = 3'd0;
    end else if (update) begin
      data_d = in;
      left_d = 3'd4;
    end else if (left_q != 3'd0) begin
      crc_d  = crc_byte(crc_q, data_q[31:24]);
      data_d = {data_q[23:0], 8'h00};
      left_d = left_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      crc_q  <= '1;
      data_q <= '0;
      left_q <= 3'd0;
    end else begin
      crc_q  <= crc_d;
      data_q <= data_d;
      left_q <= left_d;
    end
  end

  assign crc_out = crc_q;
  assign done    = (left_q == 3'd0);

endmodule

// File: rtl/tx_fsm.sv
// rtl/tx_fsm.sv - reads a packet from cache word by word and emits credit-gated flits plus a CRC flit
module tx_fsm
  import chiplet_types_pkg::*;
#(
  parameter  int NUM_VC         = 2,
  parameter  int CREDITS_PER_VC = 8,
  localparam int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [8:0]        pkt_addr,
  input  logic [VC_W-1:0]   vc,
  input  flit_meta_t        metadata,
  output logic              cache_ren,
  output logic [8:0]        cache_addr,
  input  word_t             cache_rdata,
  input  logic              cache_stall,
  output logic              flit_valid,
  input  logic              flit_ready,
  output word_t             flit_payload,
  output flit_meta_t        flit_metadata,
  output logic [VC_W-1:0]   flit_vc,
  input  logic [NUM_VC-1:0] credit_return,
  output logic              busy,
  output logic              done,
  output logic              len_error
);

  localparam int CRED_W = $clog2(CREDITS_PER_VC + 1);

  tx_state_t                   state_q, state_d;
  logic [8:0]                  addr_q, addr_d;
  word_t                       flit_q, flit_d;
  flit_meta_t                  meta_q, meta_d;
  logic [VC_W-1:0]             vc_q, vc_d;
  logic [PKT_LENGTH_WIDTH-1:0] len_q, len_d;
  logic [PKT_LENGTH_WIDTH-1:0] cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        len_err_q, len_err_d;
  logic [CRED_W-1:0]           credit_q [NUM_VC];
  logic [CRED_W-1:0]           credit_d [NUM_VC];

  logic  accept;
  logic  crc_clear, crc_update, crc_done;
  word_t crc_out;

  // Credit only drops on our own acceptance, so valid cannot fall while a flit is pending.
  assign flit_valid = ((state_q == ST_SEND) || (state_q == ST_SEND_CRC)) && (credit_q[vc_q] != '0);
  assign accept     = flit_valid & flit_ready;
  assign crc_clear  = (state_q == ST_IDLE) & start;
  assign crc_update = (state_q == ST_SEND) & accept;

  socetlib_crc u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear),
    .update  (crc_update),
    .in      (flit_q),
    .crc_out (crc_out),
    .done    (crc_done)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    flit_d    = flit_q;
    meta_d    = meta_q;
    vc_d      = vc_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    len_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = pkt_addr;
          vc_d    = vc;
          meta_d  = metadata;
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!cache_stall) begin
          flit_d  = cache_rdata;
          state_d = ST_SEND;
          if (cnt_q == '0) begin
            len_d = expected_num_flits(cache_rdata);
            if (expected_num_flits(cache_rdata) == '0) begin
              len_err_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
      end
      ST_SEND: begin
        if (accept) begin
          addr_d  = addr_q + 9'd4;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_CRC_WAIT;
        end
      end
      ST_CRC_WAIT: begin
        if (crc_done) begin
          if (cnt_q == len_q) begin
            flit_d  = crc_out;
            state_d = ST_SEND_CRC;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_SEND_CRC: begin
        if (accept) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_VC; i++) begin
      credit_d[i] = credit_q[i];
      if (credit_return[i] && !(accept && (vc_q == VC_W'(i)))) begin
        if (credit_q[i] != CRED_W'(CREDITS_PER_VC)) credit_d[i] = credit_q[i] + CRED_W'(1);
      end else if (!credit_return[i] && accept && (vc_q == VC_W'(i))) begin
        credit_d[i] = credit_q[i] - CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      flit_q    <= '0;
      meta_q    <= '0;
      vc_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= CRED_W'(CREDITS_PER_VC);
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      flit_q    <= flit_d;
      meta_q    <= meta_d;
      vc_q      <= vc_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign cache_ren     = (state_q == ST_READ);
  assign cache_addr    = addr_q;
  assign flit_payload  = flit_q;
  assign flit_metadata = meta_q;
  assign flit_vc       = vc_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign len_error     = len_err_q;

endmodule

// File: tb/tb_tx_fsm.sv
// tb/tb_tx_fsm.sv - directed and randomized bench for tx_fsm against a packet-level reference model
module tb_tx_fsm;

  localparam int NUM_VC = 2;
  localparam int CPV    = 8;

  logic              clk = 1'b0;
  logic              n_rst, start;
  logic [8:0]        pkt_addr;
  logic [0:0]        vc;
  logic [6:0]        metadata;
  logic              cache_ren;
  logic [8:0]        cache_addr;
  logic [31:0]       cache_rdata;
  logic              cache_stall;
  logic              flit_valid, flit_ready;
  logic [31:0]       flit_payload;
  logic [6:0]        flit_metadata;
  logic [0:0]        flit_vc;
  logic [NUM_VC-1:0] credit_return;
  logic              busy, done, len_error;

  always #5 clk = ~clk;

  tx_fsm #(.NUM_VC(NUM_VC), .CREDITS_PER_VC(CPV)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pkt_addr(pkt_addr), .vc(vc), .metadata(metadata),
    .cache_ren(cache_ren), .cache_addr(cache_addr), .cache_rdata(cache_rdata), .cache_stall(cache_stall),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_payload(flit_payload),
    .flit_metadata(flit_metadata), .flit_vc(flit_vc), .credit_return(credit_return),
    .busy(busy), .done(done), .len_error(len_error)
  );

  logic [31:0] mem [128];
  assign cache_rdata = mem[cache_addr[8:2]];

  typedef struct packed {
    logic [31:0] p;
    logic [6:0]  m;
    logic [0:0]  v;
  } exp_flit_t;

  exp_flit_t         exp_q[$];
  logic [8:0]        addr_q[$];
  int                model_cred [NUM_VC];
  int                pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int                exp_done, exp_lerr, done_cnt, lerr_cnt, acc_cnt, valid_cycles, read_cnt;
  bit                rnd_ready, rnd_stall, rnd_ret, rnd_start;
  int                stall_at = -1, stall_left = 0;
  logic [NUM_VC-1:0] ret_once;
  bit                hold_pending;
  logic [31:0]       hold_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 31; b >= 0; b--) begin
      fb = r[31] ^ w[b];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  task automatic clear_counts();
    exp_done = 0; exp_lerr = 0; done_cnt = 0; lerr_cnt = 0;
    acc_cnt = 0; valid_cycles = 0; read_cnt = 0;
  endtask

  task automatic step();
    bit          acc;
    bit          hold_next;
    logic [0:0]  vc_s;
    logic [NUM_VC-1:0] ret_s;
    exp_flit_t   e;
    logic [8:0]  ea;
    if (rnd_ready) flit_ready = ($urandom_range(0, 3) != 0);
    credit_return = ret_once;
    if (rnd_ret)
      for (int i = 0; i < NUM_VC; i++) if ($urandom_range(0, 3) == 0) credit_return[i] = 1'b1;
    if (stall_at >= 0) begin
      cache_stall = cache_ren && (read_cnt == stall_at) && (stall_left > 0);
      if (cache_stall) stall_left--;
    end else begin
      cache_stall = rnd_stall && ($urandom_range(0, 2) == 0);
    end
    if (rnd_start && busy && !start && $urandom_range(0, 7) == 0) begin
      start    = 1'b1;
      pkt_addr = 9'($urandom());
      vc       = 1'($urandom());
      metadata = 7'($urandom());
    end

    acc   = flit_valid && flit_ready;
    vc_s  = flit_vc;
    ret_s = credit_return;
    if (flit_valid) begin
      valid_cycles++;
      chk("credit_gate", model_cred[flit_vc] > 0, 1);
    end
    if (hold_pending) begin
      chk("valid_hold", flit_valid, 1);
      chk("payload_hold", flit_payload, hold_p);
    end
    if (cache_ren && cache_stall) chk("no_valid_in_stall", flit_valid, 0);
    if (cache_ren && !cache_stall) begin
      chk("read_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) begin
        ea = addr_q.pop_front();
        chk("cache_addr", cache_addr, ea);
      end
      read_cnt++;
    end
    if (acc) begin
      acc_cnt++;
      chk("flit_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("flit_payload", flit_payload, e.p);
        chk("flit_metadata", flit_metadata, e.m);
        chk("flit_vc", flit_vc, e.v);
      end
    end
    if (done) done_cnt++;
    if (len_error) lerr_cnt++;
    hold_next = flit_valid && !flit_ready;
    hold_p    = flit_payload;

    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_VC; i++) begin
      if (ret_s[i] && !(acc && vc_s == 1'(i))) model_cred[i] = (model_cred[i] < CPV) ? model_cred[i] + 1 : CPV;
      else if (!ret_s[i] && acc && vc_s == 1'(i)) model_cred[i] = model_cred[i] - 1;
    end
    start         = 1'b0;
    ret_once      = '0;
    credit_return = '0;
    hold_pending  = hold_next;
  endtask

  task automatic set_pkt(input logic [8:0] a, input int n);
    logic [31:0] w;
    logic [6:0]  idx;
    idx = a[8:2];
    w = $urandom();
    w[7:0] = 8'(n);
    mem[idx] = w;
    for (int k = 1; k < n; k++) begin
      idx = idx + 7'd1;
      mem[idx] = $urandom();
    end
  endtask

  task automatic start_pkt(input logic [8:0] a, input logic [0:0] v, input logic [6:0] m);
    int          n;
    logic [31:0] c, w;
    logic [8:0]  ad;
    w  = mem[a[8:2]];
    n  = int'(w[7:0]);
    c  = 32'hFFFF_FFFF;
    ad = a;
    if (n == 0) begin
      addr_q.push_back(a);
      exp_lerr++;
    end
    for (int k = 0; k < n; k++) begin
      w = mem[ad[8:2]];
      addr_q.push_back(ad);
      exp_q.push_back('{p: w, m: m, v: v});
      c  = crc_word(c, w);
      ad = ad + 9'd4;
    end
    if (n > 0) begin
      exp_q.push_back('{p: c, m: m, v: v});
      exp_done++;
    end
    pkt_addr = a;
    vc       = v;
    metadata = m;
    start    = 1'b1;
    step();
  endtask

  task automatic end_pkt(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
    step();
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_len_error_cnt"}, lerr_cnt, exp_lerr);
    chk({tag, "_reads_left"}, addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flit_valid"}, flit_valid, 0);
    chk({tag, "_cache_ren"}, cache_ren, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len_error"}, len_error, 0);
    chk({tag, "_cache_addr"}, cache_addr, 0);
    chk({tag, "_flit_payload"}, flit_payload, 0);
    chk({tag, "_flit_metadata"}, flit_metadata, 0);
    chk({tag, "_flit_vc"}, flit_vc, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [8:0] a;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    n_rst = 1'b1; start = 1'b0; pkt_addr = '0; vc = '0; metadata = '0;
    cache_stall = 1'b0; flit_ready = 1'b1; credit_return = '0; ret_once = '0;
    rnd_ready = 0; rnd_stall = 0; rnd_ret = 0; rnd_start = 0; hold_pending = 0;
    for (int i = 0; i < NUM_VC; i++) model_cred[i] = CPV;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b0;
    check_reset_outputs("reset");

    // 3-flit packet, always ready, no stalls
    set_pkt(9'h040, 3);
    start_pkt(9'h040, 1'b0, 7'h2A);
    end_pkt("basic", 200);
    chk("basic_flits", acc_cnt, 4);

    // credits return while idle, with one extra pulse that must saturate
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      ret_once = 2'b01;
      step();
    end

    // 5-cycle stall on the second read, address wrapping past 511
    clear_counts();
    stall_at = 1; stall_left = 5;
    set_pkt(9'h1F8, 3);
    start_pkt(9'h1F8, 1'b0, 7'h15);
    end_pkt("stall", 200);
    chk("stall_applied", stall_left, 0);
    chk("stall_flits", acc_cnt, 4);
    stall_at = -1;

    // saturate VC1 then drain it down to 2 credits
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      ret_once = 2'b10;
      step();
    end
    set_pkt(9'h080, 5);
    start_pkt(9'h080, 1'b1, 7'h33);
    end_pkt("drain", 300);

    // 2 credits for a 3-flit packet: stalls after 2, one return per further flit
    clear_counts();
    set_pkt(9'h0C0, 3);
    start_pkt(9'h0C0, 1'b1, 7'h4C);
    repeat (40) step();
    chk("credit_stall_flits", acc_cnt, 2);
    chk("credit_stall_busy", busy, 1);
    chk("credit_stall_valid", flit_valid, 0);
    ret_once = 2'b10;
    repeat (20) step();
    chk("credit_release_flits", acc_cnt, 3);
    chk("crc_waits_credit", flit_valid, 0);
    chk("crc_pending", exp_q.size(), 1);
    flit_ready = 1'b0;
    ret_once = 2'b10;
    step();
    chk("crc_valid_after_return", flit_valid, 1);
    flit_ready = 1'b1;
    ret_once = 2'b10;
    step();
    end_pkt("credit", 50);
    chk("credit_flits", acc_cnt, 4);

    // return on the acceptance cycle left exactly one credit on VC1
    clear_counts();
    set_pkt(9'h100, 3);
    start_pkt(9'h100, 1'b1, 7'h01);
    repeat (30) step();
    chk("one_credit_flits", acc_cnt, 1);
    chk("one_credit_busy", busy, 1);
    rnd_ret = 1;
    end_pkt("one_credit", 300);
    rnd_ret = 0;

    // header decoding to zero flits
    clear_counts();
    set_pkt(9'h140, 0);
    start_pkt(9'h140, 1'b0, 7'h7F);
    end_pkt("zero_len", 50);
    chk("zero_len_no_valid", valid_cycles, 0);

    // reset in CRC_WAIT of flit 2, then a packet needing all 8 credits
    clear_counts();
    set_pkt(9'h180, 4);
    start_pkt(9'h180, 1'b0, 7'h5A);
    n = 0;
    while (acc_cnt < 2 && n < 60) begin
      step();
      n++;
    end
    chk("reset_reached_flit2", acc_cnt, 2);
    chk("reset_in_crc_wait_busy", busy, 1);
    chk("reset_in_crc_wait_valid", flit_valid, 0);
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    for (int i = 0; i < NUM_VC; i++) model_cred[i] = CPV;
    exp_q.delete();
    addr_q.delete();
    hold_pending = 0;
    clear_counts();
    check_reset_outputs("mid_reset");
    repeat (10) step();
    chk("after_reset_quiet", valid_cycles, 0);
    set_pkt(9'h1C0, 7);
    start_pkt(9'h1C0, 1'b0, 7'h22);
    end_pkt("after_reset", 300);
    chk("after_reset_flits", acc_cnt, 8);

    // randomized packets with random ready, stalls, returns and ignored starts
    rnd_ready = 1; rnd_stall = 1; rnd_ret = 1; rnd_start = 1;
    for (int p = 0; p < 12; p++) begin
      clear_counts();
      a = 9'($urandom()) & 9'h1FC;
      set_pkt(a, $urandom_range(0, 5));
      start_pkt(a, 1'($urandom()), 7'($urandom()));
      end_pkt("random", 600);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tx_fsm.md
TX_FSM -- requirements
Module: tx_fsm

Interface
REQ-001 SHALL have parameter NUM_VC, default 2, number of virtual channels.
REQ-002 SHALL have parameter CREDITS_PER_VC, default 8, initial and maximum credits per VC.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port n_rst, input, 1, reset; synchronous and active-high (name kept for codebase consistency).
REQ-005 SHALL have port start, input, 1, pulse requesting transmission of one packet.
REQ-006 SHALL have ports pkt_addr (input, 9, cache byte address of header word), vc (input, $clog2(NUM_VC), target VC) and metadata (input, 7, {id, req} for every flit).
REQ-007 SHALL have ports cache_ren (output, 1), cache_addr (output, 9), cache_rdata (input, 32) and cache_stall (input, 1, read not yet complete).
REQ-008 SHALL have ports flit_valid (output, 1), flit_ready (input, 1), flit_payload (output, 32), flit_metadata (output, 7) and flit_vc (output, $clog2(NUM_VC)).
REQ-009 SHALL have port credit_return, input, NUM_VC, one-cycle credit-return pulse per VC.
REQ-010 SHALL have ports busy (output, 1, not IDLE), done (output, 1, one-cycle pulse after CRC flit accepted) and len_error (output, 1, one-cycle pulse when header decodes to zero flits).

Function
REQ-011 SHALL implement states IDLE, READ, SEND, CRC_WAIT, SEND_CRC.
REQ-012 IDLE: start SHALL latch pkt_addr, vc and metadata, clear the CRC engine and the flit counter, and go to READ; start outside IDLE SHALL be ignored.
REQ-013 READ: cache_ren SHALL be 1 with cache_addr = current address; while cache_stall=1 the FSM SHALL stay; on cache_stall=0 it SHALL capture cache_rdata into the flit register and go to SEND.
REQ-014 When the first word (header) is captured, packet length SHALL be latched as expected_num_flits(cache_rdata) (non-CRC flits, header included).
REQ-015 If the latched length is 0, the FSM SHALL pulse len_error and return to IDLE without emitting any flit.
REQ-016 SEND: flit_valid SHALL be 1 only while credit[vc] > 0; flit_payload, flit_metadata and flit_vc SHALL be stable until accepted.
REQ-017 A flit is accepted on flit_valid & flit_ready; on acceptance, credit[vc] SHALL decrement, the CRC engine SHALL receive a one-cycle update with the payload, the address SHALL advance by 4 (mod 512), the flit count SHALL increment, and the FSM SHALL go to CRC_WAIT.
REQ-018 CRC_WAIT: the FSM SHALL wait for CRC done, then go to SEND_CRC if count == length, else to READ.
REQ-019 SEND_CRC: payload SHALL be crc_out, subject to the same credit gating; on acceptance, credit[vc] SHALL decrement, done SHALL pulse and the FSM SHALL return to IDLE.
REQ-020 Each credit counter SHALL increment on credit_return[i] and decrement on its own flit acceptance; both in one cycle SHALL leave it unchanged; an increment at CREDITS_PER_VC SHALL saturate.
REQ-021 Credit counters SHALL operate in every state, IDLE included.
REQ-022 flit_valid SHALL never fall without acceptance once raised in SEND or SEND_CRC (credit is checked only before the rise).

Reset
REQ-023 On n_rst=1 at a clk edge: state SHALL be IDLE, all credits SHALL equal CREDITS_PER_VC, the CRC engine SHALL be cleared, and cache_ren, flit_valid, done, len_error and busy SHALL be 0.
REQ-024 Reset mid-packet SHALL abandon the packet with no further flits; the outputs cache_addr, flit_payload, flit_metadata and flit_vc SHALL reset to 0.

Structure
REQ-025 The flit metadata typedef, word_t, PKT_LENGTH_WIDTH and expected_num_flits SHALL come from chiplet_types_pkg.
REQ-026 The CRC SHALL use the sub-module socetlib_crc; no other sub-modules are required.

Verification
REQ-027 Case 3-flit packet, ready always 1, no stalls: output SHALL be 3 flits then the CRC flit, whose CRC matches a software model; done SHALL pulse once, and addresses SHALL be pkt_addr, +4, +8.
REQ-028 Case cache_stall held for 5 cycles on the 2nd read: no flit_valid during the stall, and payload order SHALL be preserved.
REQ-029 Case CREDITS_PER_VC=2 on a 3-flit packet with no returns: the FSM SHALL stall in SEND after 2 flits; one credit_return SHALL release flit 3; the CRC flit SHALL wait for the next return.
REQ-030 Case credit_return on the flit-acceptance cycle with credit=1: the count SHALL remain 1.
REQ-031 Case header decoding to 0: len_error SHALL pulse once, with no flit_valid and no done.
REQ-032 Case reset asserted in CRC_WAIT of flit 2, then a new start: the FSM SHALL send the new packet cleanly, with credits equal to CREDITS_PER_VC.
